// File: rtl/pulse_train_sched_if.sv
// Request/config/status bundle between control logic and the pulse scheduler.
// Holds the per-channel request and config buses plus the grant, pulse and done outputs.
interface pulse_train_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int CW  = 4
);
  logic [NCH-1:0]    req;
  logic [NCH*W-1:0]  cfg_high;
  logic [NCH*W-1:0]  cfg_low;
  logic [NCH*CW-1:0] cfg_count;
  logic              abort;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    pulse;
  logic [NCH-1:0]    done;
  logic              busy;

  modport master (
    output req, cfg_high, cfg_low, cfg_count, abort,
    input  gnt, pulse, done, busy
  );

  modport slave (
    input  req, cfg_high, cfg_low, cfg_count, abort,
    output gnt, pulse, done, busy
  );
endinterface

// File: rtl/pulse_train_sched.sv
// Round-robin scheduler that drives one shared pulse engine.
// The engine generates a counted high/low train on the granted channel.
module pulse_train_sched #(
  parameter  int NCH = 4,
  parameter  int W   = 8,
  parameter  int CW  = 4,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input logic            clock,
  input logic            reset,
  pulse_train_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]     state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  ch;
  logic [W-1:0]   hi_m1;
  logic [W-1:0]   lo_m1;
  logic [W-1:0]   cnt;
  logic [CW-1:0]  rem;
  logic [NCH-1:0] gnt_r;
  logic [NCH-1:0] pulse_r;
  logic [NCH-1:0] done_r;
  logic           busy_r;

  logic           found;
  logic [IW-1:0]  win;
  logic [NCH-1:0] win_oh;
  logic [W-1:0]   sel_h;
  logic [W-1:0]   sel_l;
  logic [CW-1:0]  sel_n;
  logic [W-1:0]   sel_hm1;
  logic [W-1:0]   sel_lm1;
  logic [CW-1:0]  sel_rem;

  // First requester strictly after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_oh = NCH'(1) << win;
  assign sel_h  = bus.cfg_high[int'(win)*W +: W];
  assign sel_l  = bus.cfg_low[int'(win)*W +: W];
  assign sel_n  = bus.cfg_count[int'(win)*CW +: CW];

  // Zero-length fields behave as length one.
  assign sel_hm1 = (sel_h == '0) ? '0 : sel_h - W'(1);
  assign sel_lm1 = (sel_l == '0) ? '0 : sel_l - W'(1);
  assign sel_rem = (sel_n == '0) ? CW'(1) : sel_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= IW'(NCH - 1);
      ch      <= '0;
      hi_m1   <= '0;
      lo_m1   <= '0;
      cnt     <= '0;
      rem     <= '0;
      gnt_r   <= '0;
      pulse_r <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            ch      <= win;
            hi_m1   <= sel_hm1;
            lo_m1   <= sel_lm1;
            cnt     <= sel_hm1;
            rem     <= sel_rem;
            gnt_r   <= win_oh;
            pulse_r <= win_oh;
            busy_r  <= 1'b1;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (bus.abort) begin
            state   <= IDLE;
            gnt_r   <= '0;
            pulse_r <= '0;
            busy_r  <= 1'b0;
            ptr     <= ch;
          end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
          end else if (rem == CW'(1)) begin
            state   <= DONE;
            pulse_r <= '0;
            done_r  <= gnt_r;
          end else begin
            state   <= LOW;
            rem     <= rem - CW'(1);
            cnt     <= lo_m1;
            pulse_r <= '0;
          end
        end
        LOW: begin
          if (bus.abort) begin
            state   <= IDLE;
            gnt_r   <= '0;
            pulse_r <= '0;
            busy_r  <= 1'b0;
            ptr     <= ch;
          end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
          end else begin
            state   <= HIGH;
            cnt     <= hi_m1;
            pulse_r <= gnt_r;
          end
        end
        DONE: begin
          state  <= IDLE;
          gnt_r  <= '0;
          busy_r <= 1'b0;
          ptr    <= ch;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.pulse = pulse_r;
  assign bus.done  = done_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_pulse_train_sched.sv
// Scoreboard bench for pulse_train_sched: expected busy-cycle samples are
// queued with the stimulus and checked by an independent monitor.
module tb_pulse_train_sched;

  logic clock = 1'b0;
  logic reset = 1'b1;
  bit   mon_en = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  int   gap = 100;

  always #5 clock = ~clock;

  pulse_train_sched_if #(.NCH(4), .W(8), .CW(4)) bus ();

  pulse_train_sched #(.NCH(4), .W(8), .CW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] d;
    int         gap;
  } exp_t;

  exp_t q[$];

  task automatic add(input logic [3:0] g, input logic [3:0] p,
                     input logic [3:0] d, input int gap0,
                     input int lim, inout int k);
    exp_t e;
    if (lim < 0 || k < lim) begin
      e.g = g;
      e.p = p;
      e.d = d;
      e.gap = (k == 0) ? gap0 : 0;
      q.push_back(e);
    end
    k++;
  endtask

  // Expected busy-cycle samples for one train, optionally truncated at lim.
  task automatic train(input int c, input int h, input int l, input int n,
                       input int gap0, input int lim);
    logic [3:0] oh;
    int k;
    oh = 4'b0001 << c;
    k = 0;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) add(oh, oh, 4'b0, gap0, lim, k);
      if (p < n - 1)
        for (int i = 0; i < l; i++) add(oh, 4'b0, 4'b0, gap0, lim, k);
    end
    add(oh, 4'b0, oh, gap0, lim, k);
  endtask

  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      vectors++;
      if (bus.busy) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_busy gnt=%b pulse=%b done=%b want idle",
                   bus.gnt, bus.pulse, bus.done);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.gnt !== e.g || bus.pulse !== e.p || bus.done !== e.d ||
              (e.gap >= 0 && gap != e.gap)) begin
            errors++;
            $display("FAIL sample got g=%b p=%b d=%b gap=%0d want g=%b p=%b d=%b gap=%0d",
                     bus.gnt, bus.pulse, bus.done, gap, e.g, e.p, e.d, e.gap);
          end
        end
        gap = 0;
      end else begin
        if ((bus.gnt | bus.pulse | bus.done) !== 4'b0) begin
          errors++;
          $display("FAIL idle_outputs got g=%b p=%b d=%b want 0000",
                   bus.gnt, bus.pulse, bus.done);
        end
        gap++;
      end
    end
  end

  task automatic set_cfg(input int c, input int h, input int l, input int n);
    bus.cfg_high[c*8 +: 8]  = 8'(h);
    bus.cfg_low[c*8 +: 8]   = 8'(l);
    bus.cfg_count[c*4 +: 4] = 4'(n);
  endtask

  task automatic chk_zero(input string name);
    vectors++;
    if ({bus.gnt, bus.pulse, bus.done, bus.busy} !== 13'b0) begin
      errors++;
      $display("FAIL %s got g=%b p=%b d=%b busy=%b want all 0",
               name, bus.gnt, bus.pulse, bus.done, bus.busy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 4'b0;
    bus.abort = 1'b0;
    @(negedge clock);
    mon_en = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_zero("reset_state");
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clock);
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending want 0", name, q.size());
      q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req = 4'b0;
    bus.abort = 1'b0;
    bus.cfg_high = '0;
    bus.cfg_low = '0;
    bus.cfg_count = '0;

    do_reset();
    set_cfg(1, 3, 2, 2);
    train(1, 3, 2, 2, -1, -1);
    bus.req = 4'b0010;
    @(negedge clock);
    bus.req = 4'b0;
    drain("t1_basic");

    do_reset();
    for (int c = 0; c < 4; c++) set_cfg(c, 1, 1, 1);
    train(0, 1, 1, 1, -1, -1);
    train(1, 1, 1, 1, 1, -1);
    train(2, 1, 1, 1, 1, -1);
    train(3, 1, 1, 1, 1, -1);
    train(0, 1, 1, 1, 1, -1);
    bus.req = 4'b1111;
    repeat (13) @(negedge clock);
    bus.req = 4'b0;
    drain("t2_rr");

    do_reset();
    set_cfg(2, 0, 0, 0);
    train(2, 1, 1, 1, -1, -1);
    bus.req = 4'b0100;
    @(negedge clock);
    bus.req = 4'b0;
    drain("t3_zero");

    do_reset();
    set_cfg(0, 4, 4, 3);
    set_cfg(1, 1, 1, 1);
    train(0, 4, 4, 3, -1, 6);
    train(1, 1, 1, 1, 1, -1);
    bus.req = 4'b0011;
    repeat (6) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    @(negedge clock);
    bus.req = 4'b0;
    drain("t4_abort");

    do_reset();
    set_cfg(3, 5, 3, 2);
    set_cfg(0, 1, 1, 1);
    train(3, 5, 3, 2, -1, 3);
    train(0, 1, 1, 1, 1, -1);
    bus.req = 4'b1000;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bus.req = 4'b1001;
    @(negedge clock);
    reset = 1'b0;
    chk_zero("t5_midreset");
    @(negedge clock);
    bus.req = 4'b0;
    drain("t5_reset");

    do_reset();
    set_cfg(1, 2, 2, 3);
    train(1, 2, 2, 3, -1, -1);
    bus.req = 4'b0010;
    @(negedge clock);
    bus.req = 4'b0;
    set_cfg(1, 7, 2, 3);
    drain("t6_latch");

    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_queue got %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
